// File: rtl/cpu_pkg.sv
// Shared types for the operand-fetch / effective-address sequencer.
// Holds addressing modes, sequencer states and bus direction constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        ADR_IMPL = 3'd0,
        ADR_IMM  = 3'd1,
        ADR_ZP   = 3'd2,
        ADR_ZPX  = 3'd3,
        ADR_ABS  = 3'd4,
        ADR_ABSX = 3'd5,
        ADR_IND  = 3'd6
    } adr_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_LO,
        S_OP_HI,
        S_FIX,
        S_PTR_LO,
        S_PTR_HI,
        S_DATA,
        S_DONE
    } seq_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/cpu_ea_adder.sv
// Base + index adder shared by the ZPX, ABSX and IND address paths.
// Ports: base, index, zp_wrap (keep high byte) -> sum, page_cross.
module cpu_ea_adder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] index,
    input  logic              zp_wrap,
    output logic [ADDR_W-1:0] sum,
    output logic              page_cross
);

    localparam int PAD = ADDR_W - DATA_W;

    logic [DATA_W:0]   lo_sum;
    logic [ADDR_W-1:0] full_sum;

    assign lo_sum   = {1'b0, base[DATA_W-1:0]} + {1'b0, index};
    assign full_sum = base + {{PAD{1'b0}}, index};

    assign page_cross = lo_sum[DATA_W];

    // zp_wrap keeps the high byte and lets the low byte roll over
    assign sum = zp_wrap ? {base[ADDR_W-1:DATA_W], lo_sum[DATA_W-1:0]}
                         : full_sum;

endmodule

// File: rtl/cpu_addr_seq.sv
// Operand-fetch and effective-address sequencer; owns PC and bus.
// Ports: start/mode/index/is_write/wdata_in/pc_load* from the core,
//   ready/data_bus_in from memory; drives adr_bus, data_bus_out, RW,
//   busy, done, operand, ea, pc. All state changes on negedge clk.
// Build option: CPU_IND_PAGE_BUG_EN makes the IND high-pointer fetch
//   wrap inside the pointer's page (NMOS behaviour).
module cpu_addr_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h8000)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] index,
    input  logic              is_write,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              ready,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic [ADDR_W-1:0] adr_bus,
    output logic [DATA_W-1:0] data_bus_out,
    output logic              RW,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] ea,
    output logic [ADDR_W-1:0] pc
);

    localparam int PAD = ADDR_W - DATA_W;

`ifdef CPU_IND_PAGE_BUG_EN
    localparam logic IND_WRAP = 1'b1;
`else
    localparam logic IND_WRAP = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] IDX_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    seq_state_e        state_q, state_n;
    adr_mode_e         mode_q, mode_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] adr_q, adr_n;
    logic              rw_q, rw_n;
    logic [DATA_W-1:0] dbo_q, dbo_n;
    logic [ADDR_W-1:0] ea_q, ea_n;
    logic [DATA_W-1:0] opnd_q, opnd_n;
    logic [DATA_W-1:0] lo_q, lo_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic              wr_q, wr_n;
    logic [DATA_W-1:0] idx_q, idx_n;

    logic [ADDR_W-1:0] add_base;
    logic [DATA_W-1:0] add_idx;
    logic              add_wrap;
    logic [ADDR_W-1:0] add_sum;
    logic              add_cross;

    logic              enter_data;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] hi_lo;

    assign pc_inc = pc_q + PC_ONE;
    assign hi_lo  = {data_bus_in, lo_q};

    cpu_ea_adder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_adder (
        .base       (add_base),
        .index      (add_idx),
        .zp_wrap    (add_wrap),
        .sum        (add_sum),
        .page_cross (add_cross)
    );

    // Adder operand select, one user per state
    always_comb begin
        add_base = '0;
        add_idx  = '0;
        add_wrap = 1'b0;
        unique case (state_q)
            S_OP_LO: begin
                add_base = {{PAD{1'b0}}, data_bus_in};
                add_idx  = idx_q;
                add_wrap = 1'b1;
            end
            S_OP_HI: begin
                add_base = hi_lo;
                add_idx  = idx_q;
            end
            S_PTR_LO: begin
                add_base = ptr_q;
                add_idx  = IDX_ONE;
                add_wrap = IND_WRAP;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        pc_n       = pc_q;
        adr_n      = adr_q;
        rw_n       = rw_q;
        dbo_n      = dbo_q;
        ea_n       = ea_q;
        opnd_n     = opnd_q;
        lo_n       = lo_q;
        ptr_n      = ptr_q;
        wr_n       = wr_q;
        idx_n      = idx_q;
        enter_data = 1'b0;
        data_addr  = ea_q;

        unique case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_n  = pc_load_val;
                    adr_n = pc_load_val;
                end
                if (start) begin
                    mode_n = adr_mode_e'(mode);
                    wr_n   = is_write;
                    idx_n  = index;
                    // IMPL and unused codes need no bus cycle
                    if (mode == ADR_IMPL || mode > ADR_IND)
                        state_n = S_DONE;
                    else
                        state_n = S_OP_LO;
                end
            end
            S_OP_LO: begin
                lo_n = data_bus_in;
                pc_n = pc_inc;
                case (mode_q)
                    ADR_IMM: begin
                        opnd_n  = data_bus_in;
                        adr_n   = pc_inc;
                        state_n = S_DONE;
                    end
                    ADR_ZP: begin
                        ea_n       = {{PAD{1'b0}}, data_bus_in};
                        enter_data = 1'b1;
                        data_addr  = {{PAD{1'b0}}, data_bus_in};
                    end
                    ADR_ZPX: begin
                        ea_n       = add_sum;
                        enter_data = 1'b1;
                        data_addr  = add_sum;
                    end
                    ADR_ABS, ADR_ABSX, ADR_IND: begin
                        adr_n   = pc_inc;
                        state_n = S_OP_HI;
                    end
                    default: begin
                        adr_n   = pc_inc;
                        state_n = S_DONE;
                    end
                endcase
            end
            S_OP_HI: begin
                pc_n = pc_inc;
                case (mode_q)
                    ADR_ABS: begin
                        ea_n       = hi_lo;
                        enter_data = 1'b1;
                        data_addr  = hi_lo;
                    end
                    ADR_ABSX: begin
                        ea_n = add_sum;
                        // Dummy read at the un-carried address
                        if (add_cross || wr_q) begin
                            adr_n   = {data_bus_in,
                                       add_sum[DATA_W-1:0]};
                            state_n = S_FIX;
                        end else begin
                            enter_data = 1'b1;
                            data_addr  = add_sum;
                        end
                    end
                    ADR_IND: begin
                        ptr_n   = hi_lo;
                        adr_n   = hi_lo;
                        state_n = S_PTR_LO;
                    end
                    default: begin
                        adr_n   = pc_inc;
                        state_n = S_DONE;
                    end
                endcase
            end
            S_FIX: begin
                enter_data = 1'b1;
                data_addr  = ea_q;
            end
            S_PTR_LO: begin
                lo_n    = data_bus_in;
                adr_n   = add_sum;
                state_n = S_PTR_HI;
            end
            S_PTR_HI: begin
                ea_n    = hi_lo;
                opnd_n  = '0;
                adr_n   = pc_q;
                state_n = S_DONE;
            end
            S_DATA: begin
                if (!wr_q)
                    opnd_n = data_bus_in;
                rw_n    = RW_READ;
                dbo_n   = '0;
                adr_n   = pc_q;
                state_n = S_DONE;
            end
            S_DONE: begin
                rw_n    = RW_READ;
                adr_n   = pc_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (enter_data) begin
            state_n = S_DATA;
            adr_n   = data_addr;
            rw_n    = wr_q ? RW_WRITE : RW_READ;
            dbo_n   = wr_q ? wdata_in : '0;
        end
    end

    always_ff @(negedge clk) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            mode_q  <= ADR_IMPL;
            pc_q    <= RESET_PC;
            adr_q   <= RESET_PC;
            rw_q    <= RW_READ;
            dbo_q   <= '0;
            ea_q    <= '0;
            opnd_q  <= '0;
            lo_q    <= '0;
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
        end else if (ready) begin
            state_q <= state_n;
            mode_q  <= mode_n;
            pc_q    <= pc_n;
            adr_q   <= adr_n;
            rw_q    <= rw_n;
            dbo_q   <= dbo_n;
            ea_q    <= ea_n;
            opnd_q  <= opnd_n;
            lo_q    <= lo_n;
            ptr_q   <= ptr_n;
            wr_q    <= wr_n;
            idx_q   <= idx_n;
        end
    end

    assign adr_bus      = adr_q;
    assign data_bus_out = dbo_q;
    assign RW           = rw_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE) && ready;
    assign operand      = opnd_q;
    assign ea           = ea_q;
    assign pc           = pc_q;

endmodule
